// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM state type and one-hot helper for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: combinational round-robin search; req/excl (4b) and last (2b) in, found/idx out -- first unexcluded request cyclically from last+1
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[last + SEL_W'(k)] && !excl[last + SEL_W'(k)]) begin
        found = 1'b1;
        idx = last + SEL_W'(k);
      end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-way round-robin arbiter driving mux select; clk/rst, REQ/A (4b) in, GNT (4b), S (2b), F, BUSY out; macro MUX_ARB_BURST_LIMIT_EN enables BURST_LEN forced handover
module mux_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_BURST_LIMIT_EN
#(
  parameter int BURST_LEN = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] A,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] S,
  output logic             F,
  output logic             BUSY
);
  arb_state_t state, state_n;
  logic [SEL_W-1:0] last, last_n, s_n, idx;
  logic [N_REQ-1:0] gnt_n, excl;
  logic busy_n, found, hold, take, drop;
  assign excl = state == GRANT ? GNT : '0;
  mux_rr_pick u_pick (.req(REQ), .last(last), .excl(excl), .found(found), .idx(idx));
`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] cnt, cnt_n;
  logic at_limit;
  assign at_limit = cnt >= CNT_W'(BURST_LEN - 1);
  assign hold = state == GRANT && REQ[S] && !(at_limit && found);
  assign cnt_n = take ? '0 : hold ? (at_limit ? '0 : cnt + CNT_W'(cnt != '1)) : cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : cnt_n;
`else
  assign hold = state == GRANT && REQ[S];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      GNT <= '0;
      S <= '0;
      BUSY <= 1'b0;
      last <= '1;
    end else begin
      state <= state_n;
      GNT <= gnt_n;
      S <= s_n;
      BUSY <= busy_n;
      last <= last_n;
    end
  end
  always_comb begin
    take = found && !hold;
    drop = state == GRANT && !hold && !found;
    state_n = (take || hold) ? GRANT : IDLE;
    gnt_n = take ? onehot(idx) : drop ? '0 : GNT;
    s_n = take ? idx : S;
    last_n = take ? idx : last;
    busy_n = take ? 1'b1 : drop ? 1'b0 : BUSY;
  end
  always_comb
    F = BUSY & A[S];
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] REQ = 4'b1111;
  logic [3:0] A = 4'b0000;
  logic [3:0] GNT;
  logic [1:0] S;
  logic F, BUSY;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string name;
    logic [3:0] gnt;
    logic [1:0] s;
    logic busy;
    logic f;
  } exp_t;
  exp_t q[$];
  mux_rr_arbiter dut (.clk(clk), .rst(rst), .REQ(REQ), .A(A), .GNT(GNT), .S(S), .F(F), .BUSY(BUSY));
  always #5 clk = ~clk;
  task automatic step(input string name, input logic r, input logic [3:0] rq, input logic [3:0] a_v,
                      input logic [3:0] g, input logic [1:0] s_v, input logic b, input logic f_v);
    exp_t e;
    @(negedge clk);
    rst = r;
    REQ = rq;
    A = a_v;
    e.name = name;
    e.gnt = g;
    e.s = s_v;
    e.busy = b;
    e.f = f_v;
    q.push_back(e);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({GNT, S, BUSY, F} !== {e.gnt, e.s, e.busy, e.f}) begin
          errors++;
          $display("FAIL %s: got gnt=%b s=%b busy=%b f=%b, expected gnt=%b s=%b busy=%b f=%b",
                   e.name, GNT, S, BUSY, F, e.gnt, e.s, e.busy, e.f);
        end
      end
    end
  end
  initial begin
    step("reset0", 1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    step("reset1", 1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    step("first_r0", 0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1);
    step("rr_r1", 0, 4'b1110, 4'b0010, 4'b0010, 2'd1, 1, 1);
    step("rr_r2", 0, 4'b1101, 4'b0000, 4'b0100, 2'd2, 1, 0);
    step("rr_r3", 0, 4'b1011, 4'b1000, 4'b1000, 2'd3, 1, 1);
    step("rr_wrap_r0", 0, 4'b0111, 4'b0001, 4'b0001, 2'd0, 1, 1);
    step("rel_to_r3", 0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
    step("rel_3_to_1", 0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1);
    step("hold_f_low", 0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    step("hold_other_req", 0, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1, 1);
    step("drop_idle", 0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 0, 0);
    step("stay_idle", 0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 0, 0);
    step("single_r2", 0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    step("single_drop", 0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);
    step("grant_r3", 0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
    step("mid_reset", 1, 4'b1000, 4'b1000, 4'b0000, 2'd0, 0, 0);
    step("post_reset_r0", 0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
    for (int i = 0; i < 10; i++) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
      logic own1;
      own1 = ((i + 1) / 4) % 2 == 1;
      step("burst", 0, 4'b0011, 4'b0001, own1 ? 4'b0010 : 4'b0001, own1 ? 2'd1 : 2'd0, 1, !own1);
`else
      step("no_burst_hold", 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1, 1);
`endif
    end
    step("final_drop", 0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
